// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for a small RV32I subset.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WRB) and drives the
// datapath strobes. Any encoding outside the supported subset parks the
// FSM in HALT until reset.
//
// Ports:
//   clock        single clock, rising edge
//   reset        asynchronous, active high
//   inst_out     [31:0] current instruction from the datapath
//   status_flag  [3:0]  ALU flags {V,C,N,Z}
//   RW           register-file write enable
//   MRW          data memory 1 = read, 0 = write
//   ALU_op       [3:0] ALU operation
//   C0           ALU carry-in (subtract)
//   alu_m        ALU B select, 1 = rs2, 0 = immediate
//   imm_sel      [1:0] immediate format, 00 I / 01 S / 10 B
//   WB           write-back select, 1 = memory data
//   PCsrc        1 = PC+offset, 0 = PC+4
//   pc_en        PC load enable (one retirement per pulse)
//   halted       FSM is in HALT
//   instr_count  [CNT_W-1:0] retired-instruction count
module ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inst_out,
  input  logic [3:0]       status_flag,
  output logic             RW,
  output logic             MRW,
  output logic [3:0]       ALU_op,
  output logic             C0,
  output logic             alu_m,
  output logic [1:0]       imm_sel,
  output logic             WB,
  output logic             PCsrc,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WRB, S_HALT} state_e;
  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_BNE} kind_e;

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

  typedef struct packed {
    logic       legal;
    kind_e      kind;
    logic       alu_m;
    logic [3:0] op;
    logic       c0;
    logic [1:0] imm;
    logic       wb;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc     = ins[6:0];
    f3      = ins[14:12];
    f7      = ins[31:25];
    d       = '0;
    d.kind  = K_ALU;
    d.alu_m = 1'b1;
    d.op    = OP_ADD;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          d.legal = 1'b1;
          case (f3)
            3'b000:  d.op = OP_ADD;
            3'b111:  d.op = OP_AND;
            3'b110:  d.op = OP_OR;
            3'b100:  d.op = OP_XOR;
            default: d.legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.legal = 1'b1;
          d.op    = OP_SUB;
          d.c0    = 1'b1;
        end
      end
      7'b0010011: begin
        d.legal = 1'b1;
        d.alu_m = 1'b0;
        case (f3)
          3'b000:  d.op = OP_ADD;
          3'b100:  d.op = OP_XOR;
          3'b110:  d.op = OP_OR;
          3'b111:  d.op = OP_AND;
          default: d.legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d.legal = (f3 == 3'b010);
        d.kind  = K_LW;
        d.alu_m = 1'b0;
        d.wb    = 1'b1;
      end
      7'b0100011: begin
        d.legal = (f3 == 3'b010);
        d.kind  = K_SW;
        d.alu_m = 1'b0;
        d.imm   = 2'b01;
      end
      7'b1100011: begin
        d.legal = (f3 == 3'b000) || (f3 == 3'b001);
        d.kind  = f3[0] ? K_BNE : K_BEQ;
        d.op    = OP_SUB;
        d.c0    = 1'b1;
        d.imm   = 2'b10;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  kind_e            kind_q;
  logic             alu_m_q, c0_q, wb_q;
  logic [3:0]       alu_op_q;
  logic [1:0]       imm_q;
  logic [CNT_W-1:0] cnt_q;
  dec_t             dec;
  logic             taken;

  // Only the opcode/funct fields and the Z flag steer control.
  logic unused_fields;
  assign unused_fields = ^{inst_out[24:15], inst_out[11:7], status_flag[3:1]};

  // inst_out feeds only the next-state logic and the DECODE-edge registers,
  // so no output depends combinationally on it.
  assign dec   = decode(inst_out);
  assign taken = ((kind_q == K_BEQ) &&  status_flag[0]) ||
                 ((kind_q == K_BNE) && !status_flag[0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      kind_q   <= K_ALU;
      alu_m_q  <= 1'b1;
      alu_op_q <= OP_ADD;
      c0_q     <= 1'b0;
      imm_q    <= 2'b00;
      wb_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec.legal) begin
        kind_q   <= dec.kind;
        alu_m_q  <= dec.alu_m;
        alu_op_q <= dec.op;
        c0_q     <= dec.c0;
        imm_q    <= dec.imm;
        wb_q     <= dec.wb;
      end
      if (pc_en) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    RW      = 1'b0;
    MRW     = 1'b1;
    PCsrc   = 1'b0;
    pc_en   = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec.legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (kind_q)
          K_ALU:       state_d = S_WRB;
          K_LW, K_SW:  state_d = S_MEM;
          default: begin
            PCsrc   = taken;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (kind_q == K_SW) begin
          MRW     = 1'b0;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRB;
        end
      end
      S_WRB: begin
        RW      = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Strobes are suppressed for as long as reset is high.
    if (reset) begin
      RW    = 1'b0;
      MRW   = 1'b1;
      PCsrc = 1'b0;
      pc_en = 1'b0;
    end
  end

  assign halted      = (state_q == S_HALT);
  assign ALU_op      = alu_op_q;
  assign C0          = c0_q;
  assign alu_m       = alu_m_q;
  assign imm_sel     = imm_q;
  assign WB          = wb_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

  localparam logic [2:0] K_ALU = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_BR = 3'd3, K_ILL = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_out;
  logic [3:0]  status_flag;

  logic        RW, MRW, C0, alu_m, WB, PCsrc, pc_en, halted;
  logic [3:0]  ALU_op;
  logic [1:0]  imm_sel;
  logic [15:0] instr_count;

  logic        d4_RW, d4_MRW, d4_C0, d4_alu_m, d4_WB, d4_PCsrc, d4_pc_en, d4_halted;
  logic [3:0]  d4_ALU_op;
  logic [1:0]  d4_imm_sel;
  logic [3:0]  d4_cnt;

  always #5 clock = ~clock;

  ctrl_fsm #(.CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .inst_out(inst_out), .status_flag(status_flag),
    .RW(RW), .MRW(MRW), .ALU_op(ALU_op), .C0(C0), .alu_m(alu_m), .imm_sel(imm_sel),
    .WB(WB), .PCsrc(PCsrc), .pc_en(pc_en), .halted(halted), .instr_count(instr_count)
  );

  // Narrow-counter copy sharing all stimulus, used for the wrap check.
  ctrl_fsm #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .inst_out(inst_out), .status_flag(status_flag),
    .RW(d4_RW), .MRW(d4_MRW), .ALU_op(d4_ALU_op), .C0(d4_C0), .alu_m(d4_alu_m),
    .imm_sel(d4_imm_sel), .WB(d4_WB), .PCsrc(d4_PCsrc), .pc_en(d4_pc_en),
    .halted(d4_halted), .instr_count(d4_cnt)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [3:0]  flag;
    logic [2:0]  kind;
    logic        pcs;
    logic        am;
    logic [3:0]  op;
    logic        c0;
    logic [1:0]  imm;
    logic        wb;
  } vec_t;

  typedef struct packed {
    logic        rw, mrw, pce, pcs, hlt, chk, am;
    logic [3:0]  op;
    logic        c0;
    logic [1:0]  imm;
    logic        wb;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Per-cycle expectation from the instruction class: retirement latency,
  // and which strobe fires in the retiring cycle.
  task automatic issue(input vec_t v, input int halt_cyc, input int stop_after);
    int   lat, n;
    exp_t e;
    inst_out    = v.ins;
    status_flag = v.flag;
    case (v.kind)
      K_BR:    lat = 3;
      K_SW:    lat = 4;
      K_ALU:   lat = 4;
      K_LW:    lat = 5;
      default: lat = 2 + halt_cyc;
    endcase
    n = (stop_after > 0) ? stop_after : lat;
    for (int k = 1; k <= n; k++) begin
      e     = '0;
      e.cnt = model_cnt;
      if (v.kind == K_ILL) begin
        e.mrw = 1'b1;
        e.hlt = (k >= 3);
      end else begin
        e.rw  = (k == lat) && (v.kind == K_ALU || v.kind == K_LW);
        e.mrw = !((k == lat) && (v.kind == K_SW));
        e.pce = (k == lat);
        e.pcs = (k == lat) && (v.kind == K_BR) && v.pcs;
        e.chk = (k >= 3);
        e.am  = v.am;
        e.op  = v.op;
        e.c0  = v.c0;
        e.imm = v.imm;
        e.wb  = v.wb;
      end
      expq.push_back(e);
    end
    if (v.kind != K_ILL && n == lat) model_cnt++;
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("RW",     32'(RW),     32'(e.rw));
      chk("MRW",    32'(MRW),    32'(e.mrw));
      chk("pc_en",  32'(pc_en),  32'(e.pce));
      chk("PCsrc",  32'(PCsrc),  32'(e.pcs));
      chk("halted", 32'(halted), 32'(e.hlt));
      chk("cnt16",  32'(instr_count), 32'(e.cnt[15:0]));
      chk("cnt4",   32'(d4_cnt),      32'(e.cnt[3:0]));
      if (e.chk) begin
        chk("alu_m",   32'(alu_m),   32'(e.am));
        chk("ALU_op",  32'(ALU_op),  32'(e.op));
        chk("C0",      32'(C0),      32'(e.c0));
        chk("imm_sel", 32'(imm_sel), 32'(e.imm));
        chk("WB",      32'(WB),      32'(e.wb));
      end
    end
  end

  initial begin
    vec_t ill;
    //          ins           flag   kind   pcs   am    op       c0    imm    wb
    tbl[0]  = '{32'h00500093, 4'h0, K_ALU, 1'b0, 1'b0, 4'b0011, 1'b0, 2'b00, 1'b0}; // ADDI
    tbl[1]  = '{32'h002081B3, 4'h0, K_ALU, 1'b0, 1'b1, 4'b0011, 1'b0, 2'b00, 1'b0}; // ADD
    tbl[2]  = '{32'h0020A223, 4'h0, K_SW,  1'b0, 1'b0, 4'b0011, 1'b0, 2'b01, 1'b0}; // SW
    tbl[3]  = '{32'h0000A283, 4'h0, K_LW,  1'b0, 1'b0, 4'b0011, 1'b0, 2'b00, 1'b1}; // LW
    tbl[4]  = '{32'h00208463, 4'h1, K_BR,  1'b1, 1'b1, 4'b0101, 1'b1, 2'b10, 1'b0}; // BEQ Z=1
    tbl[5]  = '{32'h00208463, 4'h0, K_BR,  1'b0, 1'b1, 4'b0101, 1'b1, 2'b10, 1'b0}; // BEQ Z=0
    tbl[6]  = '{32'h402081B3, 4'h0, K_ALU, 1'b0, 1'b1, 4'b0101, 1'b1, 2'b00, 1'b0}; // SUB
    tbl[7]  = '{32'h0020F1B3, 4'h0, K_ALU, 1'b0, 1'b1, 4'b1000, 1'b0, 2'b00, 1'b0}; // AND
    tbl[8]  = '{32'h0020E1B3, 4'h0, K_ALU, 1'b0, 1'b1, 4'b1001, 1'b0, 2'b00, 1'b0}; // OR
    tbl[9]  = '{32'h0020C1B3, 4'h0, K_ALU, 1'b0, 1'b1, 4'b1010, 1'b0, 2'b00, 1'b0}; // XOR
    tbl[10] = '{32'h0050C093, 4'h0, K_ALU, 1'b0, 1'b0, 4'b1010, 1'b0, 2'b00, 1'b0}; // XORI
    tbl[11] = '{32'h0050E093, 4'h0, K_ALU, 1'b0, 1'b0, 4'b1001, 1'b0, 2'b00, 1'b0}; // ORI
    tbl[12] = '{32'h0050F093, 4'h0, K_ALU, 1'b0, 1'b0, 4'b1000, 1'b0, 2'b00, 1'b0}; // ANDI
    tbl[13] = '{32'h00209463, 4'hE, K_BR,  1'b1, 1'b1, 4'b0101, 1'b1, 2'b10, 1'b0}; // BNE Z=0
    tbl[14] = '{32'h00209463, 4'h1, K_BR,  1'b0, 1'b1, 4'b0101, 1'b1, 2'b10, 1'b0}; // BNE Z=1
    tbl[15] = '{32'h00500093, 4'hF, K_ALU, 1'b0, 1'b0, 4'b0011, 1'b0, 2'b00, 1'b0}; // ADDI
    ill     = '{32'hFFFFFFFF, 4'h0, K_ILL, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0};

    reset = 1'b1; inst_out = '0; status_flag = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_RW", 32'(RW), 0);          chk("rst_MRW", 32'(MRW), 1);
    chk("rst_ALU_op", 32'(ALU_op), 3);  chk("rst_C0", 32'(C0), 0);
    chk("rst_alu_m", 32'(alu_m), 1);    chk("rst_imm_sel", 32'(imm_sel), 0);
    chk("rst_WB", 32'(WB), 0);          chk("rst_PCsrc", 32'(PCsrc), 0);
    chk("rst_pc_en", 32'(pc_en), 0);    chk("rst_halted", 32'(halted), 0);
    chk("rst_cnt", 32'(instr_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i], 0, 0);
      if (i == 0) chk("addi_cnt", 32'(instr_count), 1);
      if (i == 2) chk("add_sw_cnt", 32'(instr_count), 3);
      if (i == 3) chk("lw_cnt", 32'(instr_count), 4);
    end
    chk("cnt16_after16", 32'(instr_count), 16);
    chk("cnt4_wrap", 32'(d4_cnt), 0);

    // Illegal all-ones word: parks in HALT.
    issue(ill, 22, 0);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc_en", 32'(pc_en), 0);
    chk("halt_cnt", 32'(instr_count), 16);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_halt_rst_halted", 32'(halted), 0);
    chk("post_halt_rst_cnt", 32'(instr_count), 0);
    reset = 1'b0;
    model_cnt = 0;

    // Legal opcode with a bad funct3 is illegal too.
    ill.ins = 32'h0000B283;
    issue(ill, 3, 0);
    chk("bad_lw_halted", 32'(halted), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Reset arriving in the WRB cycle of an ADD.
    issue(tbl[1], 0, 3);
    reset = 1'b1;
    @(negedge clock);
    chk("midwrb_RW", 32'(RW), 0);
    chk("midwrb_pc_en", 32'(pc_en), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midwrb_cnt", 32'(instr_count), 0);
    issue(tbl[0], 0, 0);
    chk("recover_cnt", 32'(instr_count), 1);

    chk("queue_drained", 32'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter CNT_W, default 16: width of retired-instruction counter.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 inst_out  input  32  current instruction from datapath; stable while pc_en=0.
REQ-005 status_flag  input  4  ALU flags {V,C,N,Z}; bit0 = Z.
REQ-006 RW  output  1  register-file write enable, 1 = write.
REQ-007 MRW  output  1  data memory 1 = read, 0 = write.
REQ-008 ALU_op  output  4  ADD=0011, SUB=0101, AND=1000, OR=1001, XOR=1010.
REQ-009 C0  output  1  ALU carry-in; 1 only for SUB.
REQ-010 alu_m  output  1  ALU B select: 1 = register rs2, 0 = immediate.
REQ-011 imm_sel  output  2  00 = I-type, 01 = S-type, 10 = B-type.
REQ-012 WB  output  1  write-back select: 1 = memory data, 0 = ALU result.
REQ-013 PCsrc  output  1  1 = PC+offset, 0 = PC+4.
REQ-014 pc_en  output  1  PC load enable; PC advances only on cycles with pc_en=1.
REQ-015 halted  output  1  1 when FSM is in HALT.
REQ-016 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-017 States: FETCH, DECODE, EXEC, MEM, WRB, HALT; one state per clock.
REQ-018 FETCH: all strobes inactive; next DECODE.
REQ-019 DECODE: register inst_out fields internally; legal opcode -> EXEC, else -> HALT.
REQ-020 Legal set: R 0110011 (ADD/SUB by funct7 0000000/0100000 with funct3 000; AND 111, OR 110, XOR 100 with funct7 0000000); I-ALU 0010011 (ADDI 000, XORI 100, ORI 110, ANDI 111); LW 0000011/010; SW 0100011/010; BEQ/BNE 1100011/000,001; any other encoding illegal.
REQ-021 alu_m, ALU_op, C0, imm_sel, WB set in DECODE from the registered instruction; held unchanged until FSM returns to FETCH.
REQ-022 Loads/stores/I-ALU: alu_m=0, ALU_op=ADD for LW/SW, imm_sel=01 for SW, otherwise 00.
REQ-023 Branches: alu_m=1, ALU_op=SUB, C0=1, imm_sel=10.
REQ-024 EXEC: R/I-ALU -> WRB; LW/SW -> MEM; branch: sample status_flag[0], taken = (BEQ and Z=1) or (BNE and Z=0); PCsrc=taken, pc_en=1 that cycle; -> FETCH.
REQ-025 MEM: SW drives MRW=0 for exactly this one cycle, pc_en=1, -> FETCH; LW keeps MRW=1, -> WRB.
REQ-026 WRB: RW=1 for exactly one cycle, WB=1 for LW else 0, pc_en=1, PCsrc=0; -> FETCH.
REQ-027 RW and MRW=0 never asserted outside WRB/MEM respectively; never both in one cycle.
REQ-028 instr_count increments by 1 on every pc_en=1 cycle; wraps from all-ones to 0.
REQ-029 HALT: absorbing until reset; pc_en=0, RW=0, MRW=1, halted=1; instr_count frozen.
REQ-030 Latency: branch 3 cycles, SW 4, R/I-ALU 4, LW 5 (FETCH to retiring pc_en inclusive).
REQ-031 All outputs registered or decoded from state/IR only; no combinational path from inst_out to any output.

Reset
REQ-032 On reset: state=FETCH, RW=0, MRW=1, ALU_op=0011, C0=0, alu_m=1, imm_sel=00, WB=0, PCsrc=0, pc_en=0, halted=0, instr_count=0.
REQ-033 Reset asserted in any state (including mid-MEM or mid-WRB) aborts the instruction; no RW or MRW=0 pulse is emitted in the cycle reset is seen.

Verification
REQ-034 0x00500093 (ADDI x1,x0,5) after reset -> alu_m=0, ALU_op=0011, imm_sel=00, RW=1 one cycle in cycle 4, pc_en=1 same cycle, instr_count=1.
REQ-035 0x002081B3 (ADD) then 0x0020A223 (SW x2,4(x1)) -> RW pulse cycle 4; MRW=0 exactly one cycle (cycle 8) with imm_sel=01; RW stays 0 for SW; instr_count=2.
REQ-036 0x0000A283 (LW x5,0(x1)) -> MEM with MRW=1, WRB with WB=1, RW=1, retire at cycle 5.
REQ-037 0x00208463 (BEQ) with status_flag=0001 -> PCsrc=1, pc_en=1 in cycle 3, C0=1, ALU_op=0101; repeat with status_flag=0000 -> PCsrc=0.
REQ-038 0xFFFFFFFF -> HALT after DECODE, halted=1, pc_en stays 0 for 20+ cycles; reset pulse -> FETCH, halted=0, instr_count=0.
REQ-039 Reset asserted during WRB of ADD -> RW never pulses, instr_count remains 0; CNT_W=4 with 16 retirements -> instr_count wraps to 0.
